// File: rtl/atm_ctrl_multi.sv
// Multi-account ATM session controller: per-account PIN, balance, try counter and
// lockout, with an internal inactivity timeout and range-checked arithmetic.
module atm_ctrl_multi #(
   parameter int                N_ACCT      = 4,
   parameter int                BAL_W       = 16,
   parameter int                AMT_W       = 8,
   parameter int                PIN_W       = 4,
   parameter logic [PIN_W-1:0]  DEFAULT_PIN = 4'b1101,
   parameter int                INIT_BAL    = 100,
   parameter int                MAX_TRIES   = 3,
   parameter int                TIMEOUT_CYC = 1000,
   localparam int               ACCT_W      = (N_ACCT > 1) ? $clog2(N_ACCT) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              card_in,
   input  logic [ACCT_W-1:0] acct_id,
   input  logic              lang_sel,
   input  logic              lang_valid,
   input  logic [PIN_W-1:0]  pin,
   input  logic              pin_valid,
   input  logic [1:0]        op,
   input  logic [AMT_W-1:0]  amount,
   input  logic              op_valid,
   input  logic              go_main,
   input  logic              leave,
   output logic [BAL_W-1:0]  balance,
   output logic              lang,
   output logic [2:0]        state_o,
   output logic              done,
   output logic [2:0]        err_code,
   output logic              card_eject,
   output logic              locked
);

   localparam int TRY_W = $clog2(MAX_TRIES + 1);
   localparam int TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_BAD_PIN = 3'd1;
   localparam logic [2:0] ERR_LOCKED  = 3'd2;
   localparam logic [2:0] ERR_INSUF   = 3'd3;
   localparam logic [2:0] ERR_OVFL    = 3'd4;
   localparam logic [2:0] ERR_TIMEOUT = 3'd5;
   localparam logic [2:0] ERR_ZERO    = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LANG   = 3'd1,
      S_PIN    = 3'd2,
      S_MENU   = 3'd3,
      S_EXEC   = 3'd4,
      S_RESULT = 3'd5,
      S_EJECT  = 3'd6
   } state_t;

   state_t             state;
   logic               card_q;
   logic [ACCT_W-1:0]  acct_r;
   logic [1:0]         op_r;
   logic [AMT_W-1:0]   amt_r;
   logic [TO_W-1:0]    to_cnt;

   logic [BAL_W-1:0]   bal_mem  [N_ACCT];
   logic [PIN_W-1:0]   pin_mem  [N_ACCT];
   logic [TRY_W-1:0]   tries_mem[N_ACCT];
   logic               lock_mem [N_ACCT];

   logic [BAL_W-1:0]   cur_bal;
   logic [BAL_W:0]     bal_ext;
   logic [BAL_W:0]     amt_ext;
   logic [BAL_W:0]     sum_ext;
   logic [BAL_W-1:0]   diff;
   logic [TRY_W-1:0]   tries_nxt;
   logic               any_strobe;

   assign state_o = state;

   always_comb begin
      cur_bal    = bal_mem[acct_r];
      bal_ext    = {1'b0, cur_bal};
      amt_ext    = (BAL_W + 1)'(amt_r);
      sum_ext    = bal_ext + amt_ext;
      diff       = cur_bal - amt_ext[BAL_W-1:0];
      tries_nxt  = tries_mem[acct_r] + 1'b1;
      any_strobe = lang_valid | pin_valid | op_valid | go_main | leave;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         card_q     <= 1'b0;
         acct_r     <= '0;
         op_r       <= '0;
         amt_r      <= '0;
         to_cnt     <= '0;
         balance    <= '0;
         lang       <= 1'b0;
         done       <= 1'b0;
         err_code   <= ERR_NONE;
         card_eject <= 1'b0;
         locked     <= 1'b0;
         for (int unsigned i = 0; i < N_ACCT; i++) begin
            bal_mem[i]   <= BAL_W'(INIT_BAL);
            pin_mem[i]   <= DEFAULT_PIN;
            tries_mem[i] <= '0;
            lock_mem[i]  <= 1'b0;
         end
      end else begin
         card_q     <= card_in;
         done       <= 1'b0;
         card_eject <= 1'b0;
         // Only an uneventful cycle in a waiting state advances the idle counter.
         to_cnt     <= '0;
         case (state)
            S_IDLE: begin
               if (card_in && !card_q) begin
                  acct_r  <= acct_id;
                  balance <= bal_mem[acct_id];
                  locked  <= lock_mem[acct_id];
                  if (lock_mem[acct_id]) begin
                     state      <= S_EJECT;
                     err_code   <= ERR_LOCKED;
                     card_eject <= 1'b1;
                  end else begin
                     state    <= S_LANG;
                     err_code <= ERR_NONE;
                  end
               end
            end
            S_EXEC: begin
               done     <= 1'b1;
               state    <= S_RESULT;
               err_code <= ERR_NONE;
               balance  <= cur_bal;
               case (op_r)
                  2'd0: begin
                     if (amt_ext == '0) begin
                        err_code <= ERR_ZERO;
                     end else if (amt_ext > bal_ext) begin
                        err_code <= ERR_INSUF;
                     end else begin
                        bal_mem[acct_r] <= diff;
                        balance         <= diff;
                     end
                  end
                  2'd1: begin
                     if (amt_ext == '0) begin
                        err_code <= ERR_ZERO;
                     end else if (sum_ext[BAL_W]) begin
                        err_code <= ERR_OVFL;
                     end else begin
                        bal_mem[acct_r] <= sum_ext[BAL_W-1:0];
                        balance         <= sum_ext[BAL_W-1:0];
                     end
                  end
                  default: ;
               endcase
            end
            S_EJECT: begin
               if (!card_in) state <= S_IDLE;
            end
            default: begin
               if (!card_in) begin
                  state <= S_IDLE;
               end else if (leave) begin
                  state      <= S_EJECT;
                  card_eject <= 1'b1;
               end else if (any_strobe) begin
                  case (state)
                     S_LANG: begin
                        if (lang_valid) begin
                           lang  <= lang_sel;
                           state <= S_PIN;
                        end
                     end
                     S_PIN: begin
                        if (pin_valid) begin
                           if (pin == pin_mem[acct_r]) begin
                              tries_mem[acct_r] <= '0;
                              err_code          <= ERR_NONE;
                              state             <= S_MENU;
                           end else if (tries_nxt >= TRY_LIMIT) begin
                              tries_mem[acct_r] <= tries_nxt;
                              lock_mem[acct_r]  <= 1'b1;
                              locked            <= 1'b1;
                              err_code          <= ERR_LOCKED;
                              state             <= S_EJECT;
                              card_eject        <= 1'b1;
                           end else begin
                              tries_mem[acct_r] <= tries_nxt;
                              err_code          <= ERR_BAD_PIN;
                           end
                        end
                     end
                     S_MENU: begin
                        if (op_valid) begin
                           op_r  <= op;
                           amt_r <= amount;
                           if (op == 2'd3) begin
                              state      <= S_EJECT;
                              card_eject <= 1'b1;
                           end else begin
                              state <= S_EXEC;
                           end
                        end
                     end
                     S_RESULT: begin
                        if (go_main) state <= S_MENU;
                     end
                     default: ;
                  endcase
               end else if (to_cnt == TO_LAST) begin
                  state      <= S_EJECT;
                  err_code   <= ERR_TIMEOUT;
                  card_eject <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_atm_ctrl_multi.sv
// Directed bench for atm_ctrl_multi: a default-width instance plus an 8-bit balance
// instance (INIT_BAL 250) share stimulus; both use a 20-cycle idle timeout.
module tb_atm_ctrl_multi;

   logic        clk;
   logic        rst;
   logic        card_in;
   logic [1:0]  acct_id;
   logic        lang_sel;
   logic        lang_valid;
   logic [3:0]  pin;
   logic        pin_valid;
   logic [1:0]  op;
   logic [7:0]  amount;
   logic        op_valid;
   logic        go_main;
   logic        leave;

   logic [15:0] balance;
   logic        lang;
   logic [2:0]  state_o;
   logic        done;
   logic [2:0]  err_code;
   logic        card_eject;
   logic        locked;

   logic [7:0]  b_balance;
   logic        b_lang;
   logic [2:0]  b_state_o;
   logic        b_done;
   logic [2:0]  b_err_code;
   logic        b_card_eject;
   logic        b_locked;

   int n_cmp;
   int n_bad;

   atm_ctrl_multi #(.TIMEOUT_CYC(20)) dut (
      .clk(clk), .rst(rst), .card_in(card_in), .acct_id(acct_id),
      .lang_sel(lang_sel), .lang_valid(lang_valid), .pin(pin), .pin_valid(pin_valid),
      .op(op), .amount(amount), .op_valid(op_valid), .go_main(go_main), .leave(leave),
      .balance(balance), .lang(lang), .state_o(state_o), .done(done),
      .err_code(err_code), .card_eject(card_eject), .locked(locked)
   );

   atm_ctrl_multi #(.BAL_W(8), .INIT_BAL(250), .TIMEOUT_CYC(20)) dut_b (
      .clk(clk), .rst(rst), .card_in(card_in), .acct_id(acct_id),
      .lang_sel(lang_sel), .lang_valid(lang_valid), .pin(pin), .pin_valid(pin_valid),
      .op(op), .amount(amount), .op_valid(op_valid), .go_main(go_main), .leave(leave),
      .balance(b_balance), .lang(b_lang), .state_o(b_state_o), .done(b_done),
      .err_code(b_err_code), .card_eject(b_card_eject), .locked(b_locked)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic insert(input logic [1:0] a);
      acct_id = a;
      card_in = 1'b1;
      @(negedge clk);
   endtask

   task automatic remove();
      card_in = 1'b0;
      @(negedge clk);
   endtask

   task automatic give_lang(input logic l);
      lang_sel   = l;
      lang_valid = 1'b1;
      @(negedge clk);
      lang_valid = 1'b0;
   endtask

   task automatic give_pin(input logic [3:0] p);
      pin       = p;
      pin_valid = 1'b1;
      @(negedge clk);
      pin_valid = 1'b0;
   endtask

   task automatic give_op(input logic [1:0] o, input logic [7:0] a);
      op       = o;
      amount   = a;
      op_valid = 1'b1;
      @(negedge clk);
      op_valid = 1'b0;
   endtask

   task automatic pulse_go();
      go_main = 1'b1;
      @(negedge clk);
      go_main = 1'b0;
   endtask

   task automatic pulse_leave();
      leave = 1'b1;
      @(negedge clk);
      leave = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      card_in = 1'b0; acct_id = '0; lang_sel = 1'b0; lang_valid = 1'b0;
      pin = '0; pin_valid = 1'b0; op = '0; amount = '0; op_valid = 1'b0;
      go_main = 1'b0; leave = 1'b0;
      #2;
      n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL rst_state act=%0d req=0", state_o); end
      n_cmp++; if (balance !== 16'd0) begin n_bad++; $display("FAIL rst_balance act=%0d req=0", balance); end
      n_cmp++; if ({lang, done, err_code, card_eject, locked} !== 7'd0) begin n_bad++; $display("FAIL rst_outputs act=%b req=0000000", {lang, done, err_code, card_eject, locked}); end
      n_cmp++; if ({b_balance, b_lang, b_state_o, b_done, b_err_code, b_card_eject, b_locked} !== 18'd0) begin n_bad++; $display("FAIL rst_outputs_b act=%h req=0", {b_balance, b_lang, b_state_o, b_done, b_err_code, b_card_eject, b_locked}); end
      @(negedge clk);
      rst = 1'b1;
      tick();
      n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL rst_release_state act=%0d req=0", state_o); end
   endtask

   task automatic test_withdraw();
      insert(2'd0);
      n_cmp++; if (state_o !== 3'd1) begin n_bad++; $display("FAIL wd_lang_state act=%0d req=1", state_o); end
      n_cmp++; if (balance !== 16'd100) begin n_bad++; $display("FAIL wd_latched_bal act=%0d req=100", balance); end
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL wd_locked act=%0d req=0", locked); end
      give_lang(1'b1);
      n_cmp++; if (state_o !== 3'd2) begin n_bad++; $display("FAIL wd_pin_state act=%0d req=2", state_o); end
      n_cmp++; if (lang !== 1'b1) begin n_bad++; $display("FAIL wd_lang act=%0d req=1", lang); end
      give_pin(4'b1101);
      n_cmp++; if (state_o !== 3'd3) begin n_bad++; $display("FAIL wd_menu_state act=%0d req=3", state_o); end
      give_op(2'd0, 8'd30);
      n_cmp++; if (state_o !== 3'd4) begin n_bad++; $display("FAIL wd_exec_state act=%0d req=4", state_o); end
      tick();
      n_cmp++; if (state_o !== 3'd5) begin n_bad++; $display("FAIL wd_result_state act=%0d req=5", state_o); end
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL wd_done act=%0d req=1", done); end
      n_cmp++; if (balance !== 16'd70) begin n_bad++; $display("FAIL wd_balance act=%0d req=70", balance); end
      n_cmp++; if (err_code !== 3'd0) begin n_bad++; $display("FAIL wd_err act=%0d req=0", err_code); end
      tick();
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL wd_done_pulse act=%0d req=0", done); end
      pulse_go();
      n_cmp++; if (state_o !== 3'd3) begin n_bad++; $display("FAIL wd_go_main act=%0d req=3", state_o); end
      give_op(2'd2, 8'd0);
      tick();
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL bal_done act=%0d req=1", done); end
      n_cmp++; if (balance !== 16'd70) begin n_bad++; $display("FAIL bal_balance act=%0d req=70", balance); end
      n_cmp++; if (err_code !== 3'd0) begin n_bad++; $display("FAIL bal_err act=%0d req=0", err_code); end
      pulse_leave();
      n_cmp++; if (state_o !== 3'd6) begin n_bad++; $display("FAIL wd_leave_state act=%0d req=6", state_o); end
      n_cmp++; if (card_eject !== 1'b1) begin n_bad++; $display("FAIL wd_eject act=%0d req=1", card_eject); end
      remove();
      n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL wd_idle act=%0d req=0", state_o); end
      n_cmp++; if (card_eject !== 1'b0) begin n_bad++; $display("FAIL wd_eject_pulse act=%0d req=0", card_eject); end
   endtask

   task automatic test_lockout();
      insert(2'd1);
      give_lang(1'b0);
      n_cmp++; if (lang !== 1'b0) begin n_bad++; $display("FAIL lk_lang act=%0d req=0", lang); end
      give_pin(4'b1111);
      n_cmp++; if ({state_o, err_code} !== {3'd2, 3'd1}) begin n_bad++; $display("FAIL lk_try1 state/err act=%0d/%0d req=2/1", state_o, err_code); end
      give_pin(4'b0000);
      n_cmp++; if ({state_o, err_code} !== {3'd2, 3'd1}) begin n_bad++; $display("FAIL lk_try2 state/err act=%0d/%0d req=2/1", state_o, err_code); end
      give_pin(4'b0010);
      n_cmp++; if ({state_o, err_code} !== {3'd6, 3'd2}) begin n_bad++; $display("FAIL lk_try3 state/err act=%0d/%0d req=6/2", state_o, err_code); end
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lk_locked act=%0d req=1", locked); end
      n_cmp++; if (card_eject !== 1'b1) begin n_bad++; $display("FAIL lk_eject act=%0d req=1", card_eject); end
      remove();
      n_cmp++; if ({state_o, err_code} !== {3'd0, 3'd2}) begin n_bad++; $display("FAIL lk_err_held state/err act=%0d/%0d req=0/2", state_o, err_code); end
      insert(2'd1);
      n_cmp++; if ({state_o, err_code} !== {3'd6, 3'd2}) begin n_bad++; $display("FAIL lk_reinsert state/err act=%0d/%0d req=6/2", state_o, err_code); end
      n_cmp++; if ({card_eject, locked} !== 2'b11) begin n_bad++; $display("FAIL lk_reinsert eject/locked act=%b req=11", {card_eject, locked}); end
      remove();
      insert(2'd2);
      n_cmp++; if ({state_o, err_code, locked} !== {3'd1, 3'd0, 1'b0}) begin n_bad++; $display("FAIL lk_other_acct state/err/locked act=%0d/%0d/%0d req=1/0/0", state_o, err_code, locked); end
      give_lang(1'b0);
      give_pin(4'b1101);
      n_cmp++; if (state_o !== 3'd3) begin n_bad++; $display("FAIL lk_other_menu act=%0d req=3", state_o); end
      pulse_leave();
      remove();
   endtask

   task automatic test_amount_errors();
      insert(2'd0);
      give_lang(1'b0);
      give_pin(4'b1101);
      give_op(2'd0, 8'd71);
      tick();
      n_cmp++; if ({done, err_code} !== {1'b1, 3'd3}) begin n_bad++; $display("FAIL insuf done/err act=%0d/%0d req=1/3", done, err_code); end
      n_cmp++; if (balance !== 16'd70) begin n_bad++; $display("FAIL insuf_balance act=%0d req=70", balance); end
      pulse_go();
      give_op(2'd1, 8'd0);
      tick();
      n_cmp++; if ({done, err_code} !== {1'b1, 3'd6}) begin n_bad++; $display("FAIL zero_dep done/err act=%0d/%0d req=1/6", done, err_code); end
      n_cmp++; if (balance !== 16'd70) begin n_bad++; $display("FAIL zero_dep_balance act=%0d req=70", balance); end
      pulse_leave();
      remove();
   endtask

   task automatic test_overflow();
      insert(2'd3);
      give_lang(1'b0);
      give_pin(4'b1101);
      give_op(2'd1, 8'd6);
      tick();
      n_cmp++; if ({b_state_o, b_done, b_err_code} !== {3'd5, 1'b1, 3'd4}) begin n_bad++; $display("FAIL ovf state/done/err act=%0d/%0d/%0d req=5/1/4", b_state_o, b_done, b_err_code); end
      n_cmp++; if (b_balance !== 8'd250) begin n_bad++; $display("FAIL ovf_balance act=%0d req=250", b_balance); end
      n_cmp++; if (balance !== 16'd106) begin n_bad++; $display("FAIL dep_wide_balance act=%0d req=106", balance); end
      pulse_go();
      give_op(2'd1, 8'd5);
      tick();
      n_cmp++; if (b_err_code !== 3'd0) begin n_bad++; $display("FAIL dep_max_err act=%0d req=0", b_err_code); end
      n_cmp++; if (b_balance !== 8'd255) begin n_bad++; $display("FAIL dep_max_balance act=%0d req=255", b_balance); end
      n_cmp++; if (balance !== 16'd111) begin n_bad++; $display("FAIL dep_wide_balance2 act=%0d req=111", balance); end
      pulse_leave();
      n_cmp++; if ({b_card_eject, b_locked, b_lang} !== 3'b100) begin n_bad++; $display("FAIL ovf_leave eject/locked/lang act=%b req=100", {b_card_eject, b_locked, b_lang}); end
      remove();
   endtask

   task automatic test_timeout();
      insert(2'd0);
      give_lang(1'b0);
      give_pin(4'b1101);
      n_cmp++; if (state_o !== 3'd3) begin n_bad++; $display("FAIL to_menu act=%0d req=3", state_o); end
      repeat (19) tick();
      n_cmp++; if (state_o !== 3'd3) begin n_bad++; $display("FAIL to_early act=%0d req=3", state_o); end
      tick();
      n_cmp++; if ({state_o, err_code} !== {3'd6, 3'd5}) begin n_bad++; $display("FAIL to_fire state/err act=%0d/%0d req=6/5", state_o, err_code); end
      n_cmp++; if (card_eject !== 1'b1) begin n_bad++; $display("FAIL to_eject act=%0d req=1", card_eject); end
      tick();
      n_cmp++; if ({state_o, card_eject} !== {3'd6, 1'b0}) begin n_bad++; $display("FAIL to_eject_hold state/eject act=%0d/%0d req=6/0", state_o, card_eject); end
      remove();
      n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL to_idle act=%0d req=0", state_o); end
   endtask

   task automatic test_back_to_back();
      insert(2'd0);
      give_lang(1'b0);
      give_pin(4'b1101);
      give_op(2'd2, 8'd0);
      tick();
      n_cmp++; if (state_o !== 3'd5) begin n_bad++; $display("FAIL both_result act=%0d req=5", state_o); end
      go_main = 1'b1;
      leave   = 1'b1;
      tick();
      go_main = 1'b0;
      leave   = 1'b0;
      n_cmp++; if ({state_o, card_eject} !== {3'd6, 1'b1}) begin n_bad++; $display("FAIL both_leave_wins state/eject act=%0d/%0d req=6/1", state_o, card_eject); end
      remove();
   endtask

   task automatic test_card_pull();
      insert(2'd0);
      give_lang(1'b0);
      n_cmp++; if (state_o !== 3'd2) begin n_bad++; $display("FAIL pull_pin act=%0d req=2", state_o); end
      card_in = 1'b0;
      tick();
      n_cmp++; if ({state_o, card_eject} !== {3'd0, 1'b0}) begin n_bad++; $display("FAIL pull_idle state/eject act=%0d/%0d req=0/0", state_o, card_eject); end
      tick();
      n_cmp++; if ({state_o, card_eject} !== {3'd0, 1'b0}) begin n_bad++; $display("FAIL pull_no_eject state/eject act=%0d/%0d req=0/0", state_o, card_eject); end
   endtask

   task automatic test_reset_exec();
      insert(2'd0);
      give_lang(1'b0);
      give_pin(4'b1101);
      give_op(2'd0, 8'd10);
      n_cmp++; if (state_o !== 3'd4) begin n_bad++; $display("FAIL rx_exec act=%0d req=4", state_o); end
      #1 rst = 1'b0;
      #1;
      n_cmp++; if ({state_o, done, balance} !== {3'd0, 1'b0, 16'd0}) begin n_bad++; $display("FAIL rx_async state/done/bal act=%0d/%0d/%0d req=0/0/0", state_o, done, balance); end
      card_in = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick();
      insert(2'd0);
      n_cmp++; if ({state_o, balance} !== {3'd1, 16'd100}) begin n_bad++; $display("FAIL rx_bal0 state/bal act=%0d/%0d req=1/100", state_o, balance); end
      remove();
      insert(2'd1);
      n_cmp++; if ({state_o, locked} !== {3'd1, 1'b0}) begin n_bad++; $display("FAIL rx_unlock state/locked act=%0d/%0d req=1/0", state_o, locked); end
      remove();
      insert(2'd3);
      n_cmp++; if (b_balance !== 8'd250) begin n_bad++; $display("FAIL rx_bal3_b act=%0d req=250", b_balance); end
      remove();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_withdraw();
      test_lockout();
      test_amount_errors();
      test_overflow();
      test_timeout();
      test_back_to_back();
      test_card_pull();
      test_reset_exec();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
